// File: rtl/program_loader.sv
// Assembles MSB-first byte stream into instruction words and writes them to instruction memory.
// BYTES_PER_WORD+1 cycles per word minimum; rx_ready high only while collecting, busy holds the CPU off.
module program_loader #(
   parameter int INSTRUCTION_WIDTH = 40,
   parameter int PC_WIDTH          = 5,
   parameter int DEPTH             = 12
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         load_start,
   input  logic [PC_WIDTH-1:0]          load_count,
   input  logic [7:0]                   rx_data,
   input  logic                         rx_valid,
   output logic                         rx_ready,
   output logic                         wr_en,
   output logic [PC_WIDTH-1:0]          wr_addr,
   output logic [INSTRUCTION_WIDTH-1:0] wr_data,
   output logic                         busy,
   output logic                         done,
   output logic                         overflow
);

   localparam int BYTES_PER_WORD = (INSTRUCTION_WIDTH + 7) / 8;
   localparam int ASM_W          = BYTES_PER_WORD * 8;
   localparam int BC_W           = $clog2(BYTES_PER_WORD + 1);
   localparam logic [PC_WIDTH:0] DEPTH_X = (PC_WIDTH + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

   state_t                  state, state_nxt;
   // Holds every byte of the word except the last; the last comes straight from rx_data.
   logic [ASM_W-9:0]        asm_q;
   logic [ASM_W-1:0]        asm_full;
   logic [BC_W-1:0]         byte_cnt;
   logic [PC_WIDTH-1:0]     count;
   logic                    xfer;
   logic                    last_byte;
   logic                    last_word;
   logic                    count_over;

   assign xfer       = rx_valid && rx_ready;
   assign asm_full   = {asm_q, rx_data};
   assign last_byte  = (byte_cnt == BC_W'(BYTES_PER_WORD - 1));
   assign last_word  = (({1'b0, wr_addr} + (PC_WIDTH + 1)'(1)) == {1'b0, count});
   assign count_over = ({1'b0, load_count} > DEPTH_X);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (load_start) state_nxt = (load_count == '0) ? FINISH : COLLECT;
         COLLECT: if (xfer && last_byte) state_nxt = WRITE;
         WRITE:   state_nxt = last_word ? FINISH : COLLECT;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      rx_ready = 1'b0;
      wr_en    = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         COLLECT: begin rx_ready = 1'b1; busy = 1'b1; end
         WRITE:   begin wr_en = 1'b1; busy = 1'b1; end
         FINISH:  done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         asm_q    <= '0;
         byte_cnt <= '0;
         count    <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_start) begin
                  overflow <= count_over;
                  count    <= count_over ? DEPTH_X[PC_WIDTH-1:0] : load_count;
                  wr_addr  <= '0;
                  byte_cnt <= '0;
               end
            end
            COLLECT: begin
               if (xfer) begin
                  asm_q <= asm_full[ASM_W-9:0];
                  if (last_byte) begin
                     // Capture the finished word here so wr_data stays stable until the next word completes.
                     wr_data  <= asm_full[INSTRUCTION_WIDTH-1:0];
                     byte_cnt <= '0;
                  end else begin
                     byte_cnt <= byte_cnt + BC_W'(1);
                  end
               end
            end
            WRITE: begin
               if (!last_word) wr_addr <= wr_addr + PC_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Table-driven loads with a write scoreboard, plus a mid-load reset sequence.
module tb_program_loader;
   localparam int IW    = 40;
   localparam int PW    = 5;
   localparam int DEPTH = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          load_start = 1'b0;
   logic [PW-1:0] load_count = '0;
   logic [7:0]    rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_ready, wr_en, busy, done, overflow;
   logic [PW-1:0] wr_addr;
   logic [IW-1:0] wr_data;

   always #5 clk = ~clk;

   program_loader #(.INSTRUCTION_WIDTH(IW), .PC_WIDTH(PW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .load_start(load_start), .load_count(load_count),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
      .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow)
   );

   typedef struct packed {
      logic [PW-1:0] addr;
      logic [IW-1:0] data;
   } wr_t;

   typedef struct {
      logic [PW-1:0] cnt;
      logic [7:0]    seed;
      bit            toggle;
      bit            poke;
      int            exp_writes;
      int            exp_bytes;
      int            exp_collect;
      bit            exp_ovf;
   } vec_t;

   wr_t  exp_q[$];
   wr_t  mon_e;
   vec_t vecs[8];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   n_writes, n_dones, n_busy, n_ready, last_wr_cyc, done_cyc;

   function automatic logic [7:0] byte_at(int i, logic [7:0] s);
      logic [7:0] b;
      case (i % 8)
         0: b = 8'h01;
         1: b = 8'h23;
         2: b = 8'h45;
         3: b = 8'h67;
         4: b = 8'h89;
         5: b = 8'hAB;
         6: b = 8'hCD;
         default: b = 8'hEF;
      endcase
      return b ^ s;
   endfunction

   function automatic logic [IW-1:0] word_at(int w, logic [7:0] s);
      return {byte_at(5*w, s), byte_at(5*w+1, s), byte_at(5*w+2, s),
              byte_at(5*w+3, s), byte_at(5*w+4, s)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_en) begin
         n_writes++;
         last_wr_cyc = cyc;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL write_unexpected addr=%0d data=%h", wr_addr, wr_data);
         end else begin
            mon_e = exp_q.pop_front();
            if (wr_addr !== mon_e.addr || wr_data !== mon_e.data) begin
               errors++;
               $display("FAIL write_word actual addr=%0d data=%h expected addr=%0d data=%h",
                        wr_addr, wr_data, mon_e.addr, mon_e.data);
            end
         end
      end
      if (done) begin
         n_dones++;
         done_cyc = cyc;
      end
      if (busy)     n_busy++;
      if (rx_ready) n_ready++;
   end

   task automatic drive_load(input vec_t v, input int abort_bytes, output int nbytes, output int accept_cyc);
      int  idx = 0;
      int  nw;
      bit  got_done = 0;
      wr_t e;
      n_writes = 0; n_dones = 0; n_busy = 0; n_ready = 0;
      last_wr_cyc = -1; done_cyc = -1;
      if (abort_bytes > 0) nw = abort_bytes / 5;
      else                 nw = (int'(v.cnt) > DEPTH) ? DEPTH : int'(v.cnt);
      for (int w = 0; w < nw; w++) begin
         e.addr = PW'(w);
         e.data = word_at(w, v.seed);
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      load_start = 1'b1;
      load_count = v.cnt;
      @(negedge clk);
      accept_cyc = cyc;
      @(posedge clk); #1;
      load_start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rx_valid = v.toggle ? (c % 2 == 1) : 1'b1;
         rx_data  = byte_at(idx, v.seed);
         if (v.poke && c == 3) begin
            load_start = 1'b1;
            load_count = 5'd7;
         end else begin
            load_start = 1'b0;
         end
         @(negedge clk);
         if (rx_valid && rx_ready) idx++;
         if (done) got_done = 1;
         @(posedge clk); #1;
         if (got_done) break;
         if (abort_bytes > 0 && idx == abort_bytes) break;
      end
      rx_valid   = 1'b0;
      load_start = 1'b0;
      nbytes     = idx;
      if (!got_done && abort_bytes == 0) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done expected=done_pulse");
      end
   endtask

   task automatic check_row(input int r, input vec_t v, input int nbytes, input int accept_cyc);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("r%0d_writes", r), n_writes, v.exp_writes);
      check($sformatf("r%0d_bytes", r), nbytes, v.exp_bytes);
      check($sformatf("r%0d_ready_cycles", r), n_ready, v.exp_collect);
      check($sformatf("r%0d_busy_cycles", r), n_busy, v.exp_collect + v.exp_writes);
      check($sformatf("r%0d_overflow", r), overflow, v.exp_ovf);
      check($sformatf("r%0d_done_count", r), n_dones, 1);
      if (v.exp_writes > 0) check($sformatf("r%0d_done_after_write", r), done_cyc, last_wr_cyc + 1);
      else                  check($sformatf("r%0d_done_after_start", r), done_cyc, accept_cyc + 1);
      check($sformatf("r%0d_queue_left", r), exp_q.size(), 0);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_rx_ready"}, rx_ready, 0);
      check({tag, "_wr_en"}, wr_en, 0);
      check({tag, "_wr_addr"}, wr_addr, 0);
      check({tag, "_wr_data"}, wr_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_overflow"}, overflow, 0);
   endtask

   initial begin
      int   nb, ac;
      vec_t va;
      vecs[0] = '{cnt:5'd2,  seed:8'h00, toggle:0, poke:0, exp_writes:2,  exp_bytes:10, exp_collect:10, exp_ovf:0};
      vecs[1] = '{cnt:5'd1,  seed:8'h00, toggle:1, poke:0, exp_writes:1,  exp_bytes:5,  exp_collect:10, exp_ovf:0};
      vecs[2] = '{cnt:5'd0,  seed:8'h00, toggle:0, poke:0, exp_writes:0,  exp_bytes:0,  exp_collect:0,  exp_ovf:0};
      vecs[3] = '{cnt:5'd20, seed:8'h5A, toggle:0, poke:0, exp_writes:12, exp_bytes:60, exp_collect:60, exp_ovf:1};
      vecs[4] = '{cnt:5'd12, seed:8'hC3, toggle:0, poke:0, exp_writes:12, exp_bytes:60, exp_collect:60, exp_ovf:0};
      vecs[5] = '{cnt:5'd13, seed:8'h3C, toggle:0, poke:0, exp_writes:12, exp_bytes:60, exp_collect:60, exp_ovf:1};
      vecs[6] = '{cnt:5'd2,  seed:8'h77, toggle:0, poke:1, exp_writes:2,  exp_bytes:10, exp_collect:10, exp_ovf:0};
      vecs[7] = '{cnt:5'd3,  seed:8'h11, toggle:0, poke:0, exp_writes:3,  exp_bytes:15, exp_collect:15, exp_ovf:0};

      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      reset_n = 1'b1;

      for (int r = 0; r < 8; r++) begin
         drive_load(vecs[r], 0, nb, ac);
         check_row(r, vecs[r], nb, ac);
      end

      // Reset after three bytes of the second word: no write to addr 1, everything cleared.
      va = '{cnt:5'd14, seed:8'h21, toggle:0, poke:0, exp_writes:1, exp_bytes:8, exp_collect:8, exp_ovf:1};
      drive_load(va, 8, nb, ac);
      check("abort_bytes", nb, 8);
      check("abort_overflow_before_reset", overflow, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      check("abort_writes", n_writes, 1);
      check("abort_dones", n_dones, 0);
      check("abort_queue_left", exp_q.size(), 0);

      va = '{cnt:5'd1, seed:8'h42, toggle:0, poke:0, exp_writes:1, exp_bytes:5, exp_collect:5, exp_ovf:0};
      drive_load(va, 0, nb, ac);
      check_row(8, va, nb, ac);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
